// File: rtl/alu_pkg.sv
// Shared opcode encodings for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b010;
    localparam logic [OP_W-1:0] OP_ADD   = 3'b011;
    localparam logic [OP_W-1:0] OP_SUB   = 3'b100;
    localparam logic [OP_W-1:0] OP_RCL   = 3'b101;
    localparam logic [OP_W-1:0] OP_RCR   = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSB = 3'b111;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath used in stage 2 of alu_pipe.
// Optional signed saturation of ADD/SUB is enabled with ALU_SAT_EN.
module alu_core
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  fin,
    input  logic             cin_eff,
    input  logic             sat,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf
);

    logic [WIDTH-1:0] b_ext;
    logic [WIDTH:0]   sum;
    logic             arith_ovf;

    // SUB reuses the adder with inverted B; cin_eff supplies the +1 or the borrow.
    assign b_ext     = (fin == OP_SUB) ? ~b : b;
    assign sum       = {1'b0, a} + {1'b0, b_ext} + {{WIDTH{1'b0}}, cin_eff};
    assign arith_ovf = (a[WIDTH-1] == b_ext[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        y    = '0;
        cout = 1'b0;
        ovf  = 1'b0;
        case (fin)
            OP_AND:   y = a & b;
            OP_OR:    y = a | b;
            OP_XOR:   y = a ^ b;
            OP_ADD, OP_SUB: begin
                y    = sum[WIDTH-1:0];
                cout = sum[WIDTH];
                ovf  = arith_ovf;
`ifdef ALU_SAT_EN
                if (sat && arith_ovf) begin
                    y = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
                end
`endif
            end
            OP_RCL: begin
                y    = {a[WIDTH-2:0], cin_eff};
                cout = a[WIDTH-1];
            end
            OP_RCR: begin
                y    = {cin_eff, a[WIDTH-1:1]};
                cout = a[0];
            end
            default:  y = b;
        endcase
    end

`ifndef ALU_SAT_EN
    logic sat_unused;
    assign sat_unused = sat;
`endif

endmodule

// File: rtl/alu_pipe.sv
// Two-stage valid/ready ALU pipeline with registered flags and a chaining carry.
// Define ALU_SAT_EN to honour the sat request on ADD/SUB.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  fin,
    input  logic             cin,
    input  logic             chain,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             zero,
    output logic             neg,
    output logic             ovf
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_fin;
    logic             s1_cin;
    logic             s1_chain;
    logic             s1_sat;
    logic             carry_q;

    logic             adv2;
    logic             accept;
    logic             load2;
    logic             cin_eff;
    logic [WIDTH-1:0] y_c;
    logic             cout_c;
    logic             ovf_c;

    assign adv2     = !out_valid || out_ready;
    assign in_ready = !s1_valid || adv2;
    assign accept   = in_valid && in_ready;
    assign load2    = s1_valid && adv2;
    // carry_q already reflects the op just ahead, since it updates as that op enters S2.
    assign cin_eff  = s1_chain ? carry_q : s1_cin;

    alu_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .a       (s1_a),
        .b       (s1_b),
        .fin     (s1_fin),
        .cin_eff (cin_eff),
        .sat     (s1_sat),
        .y       (y_c),
        .cout    (cout_c),
        .ovf     (ovf_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_fin   <= OP_AND;
            s1_cin   <= 1'b0;
            s1_chain <= 1'b0;
            s1_sat   <= 1'b0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_fin   <= fin;
            s1_cin   <= cin;
            s1_chain <= chain;
            s1_sat   <= sat;
        end else if (adv2) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            y         <= '0;
            cout      <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
            ovf       <= 1'b0;
            carry_q   <= 1'b0;
        end else if (load2) begin
            out_valid <= 1'b1;
            y         <= y_c;
            cout      <= cout_c;
            zero      <= ~|y_c;
            neg       <= y_c[WIDTH-1];
            ovf       <= ovf_c;
            carry_q   <= cout_c;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] fin;
    logic       cin;
    logic       chain;
    logic       sat;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       ovf;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] ry;
    logic       rc, rz, rn, ro;
    logic [7:0] y_hold;

    alu_pipe #(
        .WIDTH (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .fin       (fin),
        .cin       (cin),
        .chain     (chain),
        .sat       (sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .cout      (cout),
        .zero      (zero),
        .neg       (neg),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the bundle was accepted.
    task automatic push(input logic [2:0] f, input logic [7:0] aa, input logic [7:0] bb,
                        input logic c, input logic ch, input logic s);
        int n;
        in_valid = 1'b1;
        fin = f; a = aa; b = bb; cin = c; chain = ch; sat = s;
        n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("push_timeout", 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Captures the next valid result; out_ready must be high so it drains.
    task automatic pop();
        int n;
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("pop_timeout", 1, 0);
        ry = y; rc = cout; rz = zero; rn = neg; ro = ovf;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; fin = '0;
        cin = 1'b0; chain = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_y", y, 8'h00);
        check("rst_flags", {cout, zero, neg, ovf}, 4'b0000);
        check("rst_in_ready", in_ready, 1);

        // ADD wrap to zero
        push(3'b011, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        pop();
        check("add_ff_01_y", ry, 8'h00);
        check("add_ff_01_flags", {rc, rz, rn, ro}, 4'b1100);

        // Chained pair, back-to-back
        push(3'b011, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        push(3'b011, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        pop();
        check("chain1_y", ry, 8'h00);
        pop();
        check("chain2_y", ry, 8'h01);
        check("chain2_cout", rc, 0);

        // SUB with borrow, then RCR chained off the borrow
        push(3'b100, 8'h05, 8'h07, 1'b1, 1'b0, 1'b0);
        push(3'b110, 8'h02, 8'h00, 1'b1, 1'b1, 1'b0);
        pop();
        check("sub_05_07_y", ry, 8'hFE);
        check("sub_05_07_flags", {rc, rz, rn, ro}, 4'b0010);
        pop();
        check("rcr_y", ry, 8'h01);
        check("rcr_cout", rc, 0);

        // SUB signed overflow: 0x80 - 1
        push(3'b100, 8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        pop();
        check("sub_ovf_y", ry, 8'h7F);
        check("sub_ovf_flags", {rc, rz, rn, ro}, 4'b1001);

        // RCL with explicit carry-in, AND, PASSB
        push(3'b101, 8'h81, 8'h00, 1'b1, 1'b0, 1'b0);
        pop();
        check("rcl_y", ry, 8'h03);
        check("rcl_cout", rc, 1);
        push(3'b000, 8'hF0, 8'h3C, 1'b1, 1'b0, 1'b0);
        pop();
        check("and_y", ry, 8'h30);
        check("and_cout", rc, 0);
        push(3'b111, 8'h12, 8'h9A, 1'b0, 1'b0, 1'b0);
        pop();
        check("passb_y", ry, 8'h9A);
        check("passb_neg", rn, 1);

        // Back-pressure: three ops against a stalled consumer
        out_ready = 1'b0;
        in_valid = 1'b1; fin = 3'b011; a = 8'h01; b = 8'h02; cin = 1'b0; chain = 1'b0;
        check("bp_rdy_a", in_ready, 1);
        @(negedge clk);
        fin = 3'b010; a = 8'hF0; b = 8'h0F;
        check("bp_rdy_b", in_ready, 1);
        @(negedge clk);
        fin = 3'b001; a = 8'h10; b = 8'h01;
        check("bp_rdy_c", in_ready, 0);
        y_hold = y;
        repeat (2) @(negedge clk);
        check("bp_stall_rdy", in_ready, 0);
        check("bp_stall_valid", out_valid, 1);
        check("bp_stall_y", y, y_hold);
        out_ready = 1'b1;
        check("bp_res_a", y, 8'h03);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_res_b_valid", out_valid, 1);
        check("bp_res_b", y, 8'hFF);
        @(negedge clk);
        check("bp_res_c_valid", out_valid, 1);
        check("bp_res_c", y, 8'h11);
        @(negedge clk);
        check("bp_drained", out_valid, 0);

        // Reset with two carry-producing ops in flight
        out_ready = 1'b0;
        push(3'b011, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        push(3'b011, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("flush_out_valid", out_valid, 0);
        check("flush_y", y, 8'h00);
        check("flush_in_ready", in_ready, 1);
        out_ready = 1'b1;
        push(3'b011, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0);
        pop();
        check("flush_carry_y", ry, 8'h00);
        check("flush_carry_cout", rc, 0);
        check("flush_no_stale", out_valid, 0);

        // Signed overflow with saturate request
        push(3'b011, 8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        pop();
`ifdef ALU_SAT_EN
        check("sat_add_y", ry, 8'h7F);
        check("sat_add_flags", {rc, rz, rn, ro}, 4'b0001);
`else
        check("sat_add_y", ry, 8'h80);
        check("sat_add_flags", {rc, rz, rn, ro}, 4'b0011);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, two-stage pipelined ALU; successor to the 4-bit combinational ALU.
- Operand width is generic.
- Valid/ready handshakes on input and output.
- Registered status flags: carry, zero, negative, overflow.
- An internal carry-flag register supports multi-word chained arithmetic and rotate-through-carry.
- Sits between an operand sequencer and a result consumer in the datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  in  1  system clock; one clock domain, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept a bundle this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- fin  in  3  opcode.
- cin  in  1  explicit carry-in.
- chain  in  1  1 = use the internal carry flag instead of cin.
- sat  in  1  saturate request; honoured only with ALU_SAT_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  WIDTH  result.
- cout  out  1  carry-out of this result.
- zero  out  1  y == 0.
- neg  out  1  y[WIDTH-1].
- ovf  out  1  signed overflow.

Behaviour:
- Reset: out_valid=0, y=0, cout=0, zero=0, neg=0, ovf=0, carry flag=0, stage-1 valid=0.
  - Reset mid-operation flushes both stages; in-flight ops are lost.
  - in_ready=1 on the first cycle after reset.
- Stage 1 (S1) registers a, b, fin, cin, chain and sat on in_valid && in_ready.
- Stage 2 (S2) computes from the S1 registers and registers y and the flags.
- Latency: result appears exactly 2 clocks after acceptance when there is no back-pressure. Throughput is 1 op/clock.
- Handshake:
  - adv2 = !out_valid || out_ready
  - in_ready = !s1_valid || adv2
  - S2 loads when s1_valid && adv2; out_valid clears when out_ready && !s1_valid.
- Stall rule: while out_valid && !out_ready, y and all flags hold stable.
- cin_eff = chain ? carry_q : cin.
- carry_q is updated with cout whenever an op enters S2. Strict in-order update means back-to-back chained ops see the predecessor's carry.
- Opcodes (fin):
  - 000 AND: y=a&b, cout=0.
  - 001 OR: y=a|b, cout=0.
  - 010 XOR: y=a^b, cout=0.
  - 011 ADD: {cout,y}=a+b+cin_eff.
  - 100 SUB: {cout,y}=a+~b+cin_eff. Plain subtract uses cin=1; cout=1 means no borrow.
  - 101 RCL: y={a[W-2:0],cin_eff}, cout=a[W-1].
  - 110 RCR: y={cin_eff,a[W-1:1]}, cout=a[0].
  - 111 PASSB: y=b, cout=0.
- Arithmetic is (WIDTH+1)-bit; wrap-around is modulo 2^WIDTH.
- ovf:
  - ADD: a[msb]==b[msb] && y[msb]!=a[msb].
  - SUB: same rule with ~b in place of b.
  - 0 for all other ops.
- zero and neg are derived from the final y, after any saturation.
- Simultaneous accept and drain in the same cycle is legal; there are no bubbles.

Optional Feature:
- Macro: ALU_SAT_EN.
- Defined:
  - ADD/SUB with sat=1 and signed overflow clamp y to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow).
  - ovf still reports 1; cout is unchanged.
- Undefined:
  - sat port present but ignored; results wrap.

Decomposition:
- Shared package alu_pkg holds:
  - localparams OP_AND..OP_PASSB (3-bit).
  - the opcode width constant.
- One combinational sub-module, alu_core (a, b, fin, cin_eff, sat -> y, cout, ovf), instantiated in S2.
- Pipeline registers and handshake logic stay in alu_pipe.

Test Plan:
- WIDTH=8, ADD a=FF b=01 cin=0 chain=0 -> 2 clocks later y=00, cout=1, zero=1, neg=0, ovf=0.
- Chain: ADD FF+01 then next cycle ADD 00+00 chain=1 -> second result y=01, cout=0.
- SUB a=05 b=07 cin=1 -> y=FE, cout=0, neg=1, ovf=0. Then RCR a=02 chain=1 -> y=01, cout=0 (carry_q=0 in).
- Back-pressure: out_ready=0, feed 3 ops back-to-back -> in_ready drops after 2 accepted, y stable. Raise out_ready -> 3 results in order on consecutive clocks.
- Assert rst one cycle with 2 ops in flight -> next cycle out_valid=0, y=00, in_ready=1, and carry_q=0 (a chained ADD 00+00 gives y=00).
- ADD a=7F b=01 sat=1 -> with ALU_SAT_EN y=7F, ovf=1; without it y=80, ovf=1, neg=1.
